cp0_unit: RTL and testbench

- Coprocessor-0 block for the pipelined MIPS core.
- Sits directly downstream of the two timer devices and the external interrupt line. It consumes their level IRQ outputs as HWInt[5:0].
- Holds SR, Cause, EPC and PRId, and decides exception/interrupt entry each cycle. It drives Req to flush the pipeline and redirect the PC to the handler.
- Mapping of HWInt: [0] = timer0 IRQ, [1] = timer1 IRQ, [2] = external interrupt, [5:3] = tied 0 at top level.

---
 rtl/cp0_unit.sv | 117 +++++++++++
 tb/tb_cp0_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR, Cause, EPC and PRId, with
// exception and interrupt entry decided combinationally each cycle.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h0000_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:2] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim_pc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;

    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    assign Req     = int_req | exc_req;

    // A delay-slot victim restarts at its branch so the branch is re-executed.
    assign victim_pc = BDIn ? (VPC - 32'd4) : VPC;

    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'b00};
    assign epc_val   = {epc_q, 2'b00};
    assign EPCOut    = epc_val;

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Addr)
            ADDR_SR:    CP0Out = sr_val;
            ADDR_CAUSE: CP0Out = cause_val;
            ADDR_EPC:   CP0Out = epc_val;
            ADDR_PRID:  CP0Out = PRID;
            default:    CP0Out = 32'd0;
        endcase
    end

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (Req) begin
            // Entry wins over any mtc0 issued in the same cycle.
            exl_d     = 1'b1;
            bd_d      = BDIn;
            exccode_d = int_req ? 5'd0 : ExcCodeIn;
            epc_d     = victim_pc[31:2];
        end else begin
            if (en) begin
                case (CP0Addr)
                    ADDR_SR: begin
                        im_d  = CP0In[15:10];
                        exl_d = CP0In[1];
                        ie_d  = CP0In[0];
                    end
                    ADDR_EPC: epc_d = CP0In[31:2];
                    default:  ;
                endcase
            end
            // eret overrides only the EXL bit of a concurrent SR write.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 30'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Table-driven bench for cp0_unit: each row drives one cycle of inputs and
// checks Req, CP0Out and EPCOut sampled before the next rising edge.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Addr   (CP0Addr),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        chk;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        exlclr;
        logic        exp_req;
        logic [31:0] exp_out;
        logic [31:0] exp_epc;
    } vec_t;

    typedef struct {
        int          row;
        logic        req;
        logic [31:0] out;
        logic [31:0] epc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic rst_n, input logic chk, input logic wen,
                       input logic [4:0] addr, input logic [31:0] din,
                       input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                       input logic [5:0] hw, input logic exlclr, input logic req,
                       input logic [31:0] out, input logic [31:0] epc);
        vec_t v;
        v.rst_n = rst_n; v.chk = chk; v.en = wen; v.addr = addr; v.din = din;
        v.vpc = vpc; v.bd = bd; v.exc = exc; v.hw = hw; v.exlclr = exlclr;
        v.exp_req = req; v.exp_out = out; v.exp_epc = epc;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input int row,
                           input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s row %0d: got %08h, expected %08h", name, row, act, exp_v);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst_n; en = v.en; CP0Addr = v.addr; CP0In = v.din;
        VPC = v.vpc; BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.exlclr;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        reset = 1'b0; en = 1'b0; CP0Addr = 5'd0; CP0In = 32'd0; VPC = 32'd0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;

        //   rst chk en addr din           vpc           bd exc hw      clr req out           epc
        add(0, 0, 0, 12, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h0,        32'h0);
        add(0, 1, 0, 12, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h0,        32'h0);
        add(1, 1, 0, 13, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h0,        32'h0);
        add(1, 1, 0, 14, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h0,        32'h0);
        add(1, 1, 0, 15, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h7,        32'h0);
        // timer interrupt
        add(1, 1, 1, 12, 32'h401,      32'h0,        0, 0,  6'd0, 0, 0, 32'h0,        32'h0);
        add(1, 1, 0, 12, 32'h0,        32'h3010,     0, 0,  6'd1, 0, 1, 32'h401,      32'h0);
        add(1, 1, 0, 12, 32'h0,        32'h0,        0, 0,  6'd1, 0, 0, 32'h403,      32'h3010);
        add(1, 1, 0, 13, 32'h0,        32'h0,        0, 0,  6'd1, 0, 0, 32'h400,      32'h3010);
        add(1, 1, 0, 14, 32'h0,        32'h0,        0, 0,  6'd1, 0, 0, 32'h3010,     32'h3010);
        // masked / disabled
        add(1, 1, 1, 12, 32'h800,      32'h0,        0, 0,  6'd1, 0, 0, 32'h403,      32'h3010);
        add(1, 1, 0, 13, 32'h0,        32'h0,        0, 0,  6'd2, 0, 0, 32'h400,      32'h3010);
        add(1, 1, 0, 13, 32'h0,        32'h0,        0, 0,  6'd2, 0, 0, 32'h800,      32'h3010);
        // delay-slot exception
        add(1, 1, 1, 12, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h800,      32'h3010);
        add(1, 1, 0, 13, 32'h0,        32'h3020,     1, 10, 6'd0, 0, 1, 32'h0,        32'h3010);
        add(1, 1, 0, 13, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h8000_0028, 32'h301C);
        add(1, 1, 0, 14, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h301C,     32'h301C);
        // priority: interrupt beats exception, entry beats mtc0
        add(1, 1, 1, 12, 32'h1001,     32'h0,        0, 0,  6'd0, 0, 0, 32'h2,        32'h301C);
        add(1, 1, 1, 14, 32'hDEAD_BEEF, 32'h3040,    0, 4,  6'd4, 0, 1, 32'h301C,     32'h301C);
        add(1, 1, 0, 13, 32'h0,        32'h0,        0, 0,  6'd4, 0, 0, 32'h1000,     32'h3040);
        add(1, 1, 0, 14, 32'h0,        32'h0,        0, 0,  6'd4, 0, 0, 32'h3040,     32'h3040);
        // eret with concurrent SR write, then level re-entry
        add(1, 1, 1, 12, 32'h403,      32'h0,        0, 0,  6'd1, 1, 0, 32'h1003,     32'h3040);
        add(1, 1, 0, 12, 32'h0,        32'h3050,     0, 0,  6'd1, 0, 1, 32'h401,      32'h3040);
        add(1, 1, 0, 12, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h403,      32'h3050);
        // unmapped read, read-only write, lone eret
        add(1, 1, 0, 0,  32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h0,        32'h3050);
        add(1, 1, 1, 13, 32'hFFFF_FFFF, 32'h0,       0, 0,  6'd0, 0, 0, 32'h0,        32'h3050);
        add(1, 1, 0, 13, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h0,        32'h3050);
        add(1, 1, 0, 12, 32'h0,        32'h0,        0, 0,  6'd0, 1, 0, 32'h403,      32'h3050);
        add(1, 1, 0, 12, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h401,      32'h3050);
        // EPC write masks low bits
        add(1, 1, 1, 14, 32'h0000_1237, 32'h0,       0, 0,  6'd0, 0, 0, 32'h3050,     32'h3050);
        add(1, 1, 0, 14, 32'h0,        32'h0,        0, 0,  6'd0, 0, 0, 32'h1234,     32'h1234);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            if (vecs[i].chk) begin
                e.row = i; e.req = vecs[i].exp_req;
                e.out = vecs[i].exp_out; e.epc = vecs[i].exp_epc;
                sb.push_back(e);
            end
            #1;
            if (vecs[i].chk) begin
                e = sb.pop_front();
                check32("Req", e.row, {31'd0, Req}, {31'd0, e.req});
                check32("CP0Out", e.row, CP0Out, e.out);
                check32("EPCOut", e.row, EPCOut, e.epc);
                $display("row %0d: addr=%0d Req=%0b CP0Out=%08h EPCOut=%08h",
                         e.row, CP0Addr, Req, CP0Out, EPCOut);
            end
        end

        // Mid-run reset clears everything, even with an interrupt pending.
        v = vecs[0];
        v.rst_n = 1'b0; v.hw = 6'd1;
        @(negedge clk); drive(v);
        @(negedge clk);
        v.rst_n = 1'b1; v.addr = 5'd12;
        drive(v); #1;
        check32("rst_Req", 100, {31'd0, Req}, 32'd0);
        check32("rst_SR", 100, CP0Out, 32'd0);
        check32("rst_EPC", 100, EPCOut, 32'd0);
        $display("mid-run reset: Req=%0b SR=%08h EPCOut=%08h", Req, CP0Out, EPCOut);
        @(negedge clk);
        v.addr = 5'd13; drive(v); #1;
        check32("rst_Cause_IP", 101, CP0Out, 32'h400);
        $display("post-reset Cause=%08h", CP0Out);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
